// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// alu_mc_if : instruction handshake and ALU-control bundle for alu_mc_ctrl.
//
// Purpose : groups the instruction handshake (instr_valid / instr /
//           instr_ready) with the control outputs that feed the ALU control
//           decoder and the datapath strobes.
// Modports:
//   master : instruction source / control consumer (drives instr_valid, instr)
//   slave  : alu_mc_ctrl (drives instr_ready, alu_op, func_code, strobes,
//            done, illegal, retired_cnt)
// Parameters: XLEN (instruction width, 32 only), CNT_W (retired counter width)
// ---------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic             instr_valid;
  logic [XLEN-1:0]  instr;
  logic             instr_ready;
  logic [1:0]       alu_op;
  logic [9:0]       func_code;
  logic             alu_src_imm;
  logic             mem_rd;
  logic             mem_wr;
  logic             reg_wr;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output instr_valid, instr,
    input  instr_ready, alu_op, func_code, alu_src_imm,
           mem_rd, mem_wr, reg_wr, done, illegal, retired_cnt
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, alu_op, func_code, alu_src_imm,
           mem_rd, mem_wr, reg_wr, done, illegal, retired_cnt
  );
endinterface

// File: rtl/alu_mc_ctrl.sv
// ---------------------------------------------------------------------------
// alu_mc_ctrl : multi-cycle main control FSM in front of the ALU control
//               decoder.
//
// Takes one RISC-V instruction at a time over a valid/ready handshake and
// walks it through DECODE, EXEC, MEM and WB. alu_op and func_code are
// registered when leaving DECODE and held until the next instruction's
// decode, so the combinational ALU control decoder downstream sees stable
// inputs for the whole instruction.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mc_if.slave
//           instr_valid/instr in, instr_ready out (high only in IDLE),
//           alu_op, func_code, alu_src_imm, mem_rd, mem_wr, reg_wr,
//           done, illegal, retired_cnt out (all registered)
//
// Optional feature macro: ALU_MC_PERF_CNT_EN
//   defined   -> retired_cnt is a saturating count of done pulses
//   undefined -> retired_cnt is tied to zero, no counter flops
// ---------------------------------------------------------------------------
module alu_mc_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // ALUOp class of an opcode; 2'b11 marks anything unsupported.
  function automatic logic [1:0] decode_alu_op(input logic [6:0] op);
    logic [1:0] res;
    case (op)
      OP_R:     res = 2'b10;
      OP_I:     res = 2'b01;
      OP_LOAD,
      OP_STORE,
      OP_LUI,
      OP_AUIPC: res = 2'b00;
      default:  res = 2'b11;
    endcase
    return res;
  endfunction

  state_t     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [9:0] funct_buf_q, funct_buf_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [9:0] func_code_q, func_code_d;
  logic       alu_src_imm_q, alu_src_imm_d;
  logic       ready_q, ready_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic       reg_wr_q, reg_wr_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  logic       hs_s;
  logic       is_load_s;
  logic       is_store_s;
  logic       legal_s;

  assign hs_s       = (state_q == S_IDLE) && bus.instr_valid;
  assign is_load_s  = (opcode_q == OP_LOAD);
  assign is_store_s = (opcode_q == OP_STORE);
  assign legal_s    = (decode_alu_op(opcode_q) != 2'b11);

  // Next-state logic: sequence the captured instruction through its phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) state_d = S_DECODE;
        else                 state_d = S_IDLE;
      end
      S_DECODE: begin
        if (legal_s) state_d = S_EXEC;
        else         state_d = S_ERR;
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        // Stores finish in MEM; loads still need a writeback.
        if (is_load_s) state_d = S_WB;
        else           state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture and decode: latch the instruction fields at the handshake and
  // load the ALU decoder inputs only when leaving DECODE, then hold them.
  always_comb begin
    opcode_d      = opcode_q;
    funct_buf_d   = funct_buf_q;
    alu_op_d      = alu_op_q;
    func_code_d   = func_code_q;
    alu_src_imm_d = alu_src_imm_q;
    if (hs_s) begin
      opcode_d    = bus.instr[6:0];
      funct_buf_d = {bus.instr[XLEN-1 -: 7], bus.instr[14:12]};
    end else begin
      opcode_d    = opcode_q;
      funct_buf_d = funct_buf_q;
    end
    if (state_q == S_DECODE) begin
      alu_op_d      = decode_alu_op(opcode_q);
      func_code_d   = funct_buf_q;
      alu_src_imm_d = (opcode_q != OP_R);
    end else begin
      alu_op_d      = alu_op_q;
      func_code_d   = func_code_q;
      alu_src_imm_d = alu_src_imm_q;
    end
  end

  // Moore strobes, computed from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    mem_rd_d  = (state_d == S_MEM) && is_load_s;
    mem_wr_d  = (state_d == S_MEM) && is_store_s;
    reg_wr_d  = (state_d == S_WB);
    done_d    = (state_d == S_WB) || ((state_d == S_MEM) && is_store_s);
    illegal_d = (state_d == S_ERR);
  end

  // State, captured instruction fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      opcode_q      <= 7'd0;
      funct_buf_q   <= 10'd0;
      alu_op_q      <= 2'b00;
      func_code_q   <= 10'd0;
      alu_src_imm_q <= 1'b0;
      ready_q       <= 1'b1;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct_buf_q   <= funct_buf_d;
      alu_op_q      <= alu_op_d;
      func_code_q   <= func_code_d;
      alu_src_imm_q <= alu_src_imm_d;
      ready_q       <= ready_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      reg_wr_q      <= reg_wr_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.func_code   = func_code_q;
  assign bus.alu_src_imm = alu_src_imm_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

`ifdef ALU_MC_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Retire counter: counts each done cycle, sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (done_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.retired_cnt = cnt_q;
`else
  assign bus.retired_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_mc_ctrl : self-checking bench for alu_mc_ctrl.
//
// A reference model tracks each accepted instruction as "cycles since
// handshake" and derives every output from the opcode's latency class;
// a negedge process compares all DUT outputs against it every cycle.
// Directed instructions pin the model with hand-computed literals, then
// randomized instructions (with random gaps and random junk on the bus
// while busy) exercise the rest.
// ---------------------------------------------------------------------------
module tb_alu_mc_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ALU_MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(32), .CNT_W(CNT_W)) bus ();

  alu_mc_ctrl #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- specification-level helpers ----------------
  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_LUI) || (op == OP_AUIPC);
  endfunction

  // Cycles from handshake to done (legal) or illegal pulse.
  function automatic int lat_of(input logic [6:0] op);
    if (op == OP_LOAD)     return 4;
    else if (is_legal(op)) return 3;
    else                   return 2;
  endfunction

  function automatic logic [1:0] alu_of(input logic [6:0] op);
    if (op == OP_R)        return 2'b10;
    else if (op == OP_I)   return 2'b01;
    else if (is_legal(op)) return 2'b00;
    else                   return 2'b11;
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 1'b0;
  int          m_k    = 0;     // cycles since the handshake edge
  logic [31:0] m_ins  = 32'd0;
  logic [1:0]  m_op   = 2'b00;
  logic [9:0]  m_fc   = 10'd0;
  logic        m_src  = 1'b0;
  int          m_cnt  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_op   <= 2'b00;
      m_fc   <= 10'd0;
      m_src  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (m_busy && is_legal(m_ins[6:0]) && (m_k == lat_of(m_ins[6:0])) && (m_cnt < CNT_MAX))
        m_cnt <= m_cnt + 1;
      if (!m_busy) begin
        if (bus.instr_valid) begin
          m_ins  <= bus.instr;
          m_busy <= 1'b1;
          m_k    <= 1;
        end
      end else begin
        m_k <= m_k + 1;
        if (m_k == 1) begin
          m_op  <= alu_of(m_ins[6:0]);
          m_fc  <= {m_ins[31:25], m_ins[14:12]};
          m_src <= (m_ins[6:0] != OP_R);
        end
        if (m_k == lat_of(m_ins[6:0])) m_busy <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [6:0]  c_opc;
  int          c_lat;
  bit          c_leg;
  logic [21:0] c_exp, c_act;

  always @(negedge clk) begin
    c_opc = m_ins[6:0];
    c_lat = lat_of(c_opc);
    c_leg = is_legal(c_opc);
    c_exp = { !m_busy, m_op, m_fc, m_src,
              (m_busy && c_opc == OP_LOAD  && m_k == 3),
              (m_busy && c_opc == OP_STORE && m_k == 3),
              (m_busy && c_leg && c_opc != OP_STORE && m_k == c_lat),
              (m_busy && c_leg && m_k == c_lat),
              (m_busy && !c_leg && m_k == 2),
              (PERF ? 2'(m_cnt) : 2'd0) };
    c_act = { bus.instr_ready, bus.alu_op, bus.func_code, bus.alu_src_imm,
              bus.mem_rd, bus.mem_wr, bus.reg_wr, bus.done, bus.illegal,
              bus.retired_cnt };
    n_cmp++;
    if (c_act !== c_exp) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t got {rdy,op,fc,src,rd,wr,rw,done,ill,cnt}=%b expected %b",
               $time, c_act, c_exp);
    end
  end

  // ---------------- directed-check helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         done_at;
    int         ill_at;
    int         rd_n;
    int         wr_n;
    int         wr_at;
    int         rw_n;
    int         rw_at;
    int         ready_at;
    logic [1:0] op2;
    logic [9:0] fc2;
    logic       src2;
  } obs_t;

  // Issue one instruction starting at a negedge with the DUT idle and watch
  // it until instr_ready returns; returns at that negedge.
  task automatic issue(input logic [31:0] ins, output obs_t o);
    bit got = 1'b0;
    o = '{default: 0};
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        o.ready_at = k;
        got = 1'b1;
        break;
      end
      if (bus.done    && o.done_at == 0) o.done_at = k;
      if (bus.illegal && o.ill_at  == 0) o.ill_at  = k;
      if (bus.mem_rd) o.rd_n++;
      if (bus.mem_wr) begin o.wr_n++; o.wr_at = k; end
      if (bus.reg_wr) begin o.rw_n++; o.rw_at = k; end
      if (k == 2) begin
        o.op2  = bus.alu_op;
        o.fc2  = bus.func_code;
        o.src2 = bus.alu_src_imm;
      end
      // junk on the bus while busy must be ignored
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr       = $urandom;
    end
    if (!got) chk("ready_timeout", 0, 1);
    bus.instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = OP_R;
      1: w[6:0] = OP_I;
      2: w[6:0] = OP_LOAD;
      3: w[6:0] = OP_STORE;
      4: w[6:0] = OP_LUI;
      5: w[6:0] = OP_AUIPC;
      default: w = w;
    endcase
    return w;
  endfunction

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  obs_t        ob;
  logic [31:0] ri;

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  bus.instr_ready, 1);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_func",   bus.func_code, 0);
    chk("rst_cnt",    bus.retired_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of EXEC of an R-type aborts it.
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h40B50533;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_op_before_rst", bus.alu_op, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready",  bus.instr_ready, 1);
    chk("midrst_alu_op", bus.alu_op, 0);
    chk("midrst_func",   bus.func_code, 0);
    chk("midrst_done",   bus.done, 0);
    @(negedge clk);
    chk("midrst_done_next", bus.done, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // SUB
    issue(32'h40B50533, ob);
    chk("sub_alu_op",  ob.op2, 2'b10);
    chk("sub_func",    ob.fc2, 10'b0100000000);
    chk("sub_done_at", ob.done_at, 3);
    chk("sub_rw_at",   ob.rw_at, 3);
    chk("sub_cnt",     bus.retired_cnt, PERF ? 1 : 0);

    // ORI
    issue(32'h00156513, ob);
    chk("ori_alu_op",  ob.op2, 2'b01);
    chk("ori_func",    ob.fc2, 10'b0000000110);
    chk("ori_src_imm", ob.src2, 1);
    chk("ori_done_at", ob.done_at, 3);
    chk("ori_cnt",     bus.retired_cnt, PERF ? 2 : 0);

    // LW then SW back-to-back
    issue(32'h0005A503, ob);
    chk("lw_rd_cycles", ob.rd_n, 1);
    chk("lw_done_at",   ob.done_at, 4);
    chk("lw_ready_at",  ob.ready_at, 5);
    chk("lw_cnt",       bus.retired_cnt, PERF ? 3 : 0);
    issue(32'h00A5A023, ob);
    chk("sw_wr_cycles", ob.wr_n, 1);
    chk("sw_wr_at",     ob.wr_at, 3);
    chk("sw_done_at",   ob.done_at, 3);
    chk("sw_no_reg_wr", ob.rw_n, 0);
    chk("sw_cnt_sat",   bus.retired_cnt, PERF ? 3 : 0);

    // Illegal
    issue(32'hFFFFFFFF, ob);
    chk("ill_alu_op",   ob.op2, 2'b11);
    chk("ill_pulse_at", ob.ill_at, 2);
    chk("ill_no_done",  ob.done_at, 0);
    chk("ill_ready_at", ob.ready_at, 3);
    chk("ill_cnt",      bus.retired_cnt, PERF ? 3 : 0);

    // Fifth legal instruction (LUI): counter stays saturated
    issue(32'h123450B7, ob);
    chk("lui_alu_op",  ob.op2, 2'b00);
    chk("lui_done_at", ob.done_at, 3);
    chk("lui_cnt",     bus.retired_cnt, PERF ? 3 : 0);

    // Randomized instructions with random idle gaps
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        @(negedge clk);
      end
      ri = rand_instr();
      issue(ri, ob);
      if (is_legal(ri[6:0]))
        chk("rand_done_latency", ob.done_at, lat_of(ri[6:0]));
      else
        chk("rand_illegal_latency", ob.ill_at, 2);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
